// File: rtl/next_pc_unit.sv
// Fetch-stage program counter with a one-entry redirect buffer.
// A redirect that resolves during a stall is held until the stall releases.
`timescale 1ns/1ps
module next_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] JRTarget,
  input  logic        Stall,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Flush,
  output logic        RedirectPending
);

  typedef enum logic {StRun, StPend} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_tgt_q;
  logic [31:0] sel_raw;
  logic [31:0] sel;
  logic        req;

  always_comb begin
    sel_raw = 32'h0;
    unique case (PCSrc)
      2'd0: sel_raw = 32'h0;
      2'd1: sel_raw = BranchTarget;
      2'd2: sel_raw = JumpTarget;
      2'd3: sel_raw = JRTarget;
    endcase
  end

  // Targets are always word-aligned before use.
  assign sel     = sel_raw & ~32'h3;
  assign req     = (PCSrc != 2'd0);
  assign PC      = pc_q;
  assign PCPlus4 = pc_q + 32'd4;

  // A redirect takes effect on any unstalled edge with a live or buffered request.
  assign Flush           = Reset & ~Stall & (req | (state_q == StPend));
  assign RedirectPending = (state_q == StPend);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      pend_tgt_q <= 32'h0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (!Stall) begin
            pc_q <= req ? sel : PCPlus4;
          end else if (req) begin
            pend_tgt_q <= sel;
            state_q    <= StPend;
          end
        end
        StPend: begin
          if (Stall) begin
            if (req) pend_tgt_q <= sel;
          end else begin
            // A live request beats the buffered one.
            pc_q    <= req ? sel : pend_tgt_q;
            state_q <= StRun;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed scenarios plus a randomized run
// against a queue-based reference model of the redirect rules.
`timescale 1ns/1ps
module tb_next_pc_unit;

  logic        Clk;
  logic        Reset;
  logic [1:0]  PCSrc;
  logic [31:0] BranchTarget;
  logic [31:0] JumpTarget;
  logic [31:0] JRTarget;
  logic        Stall;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        Flush;
  logic        RedirectPending;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural PC and at most one buffered target.
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_pend[$];

  next_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .PCSrc(PCSrc),
    .BranchTarget(BranchTarget),
    .JumpTarget(JumpTarget),
    .JRTarget(JRTarget),
    .Stall(Stall),
    .PC(PC),
    .PCPlus4(PCPlus4),
    .Flush(Flush),
    .RedirectPending(RedirectPending)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Advance one rising edge, updating the model from the inputs present at the edge.
  task automatic tick();
    logic [31:0] tgt;
    tgt = (PCSrc == 2'd1) ? BranchTarget : (PCSrc == 2'd2) ? JumpTarget : JRTarget;
    tgt = tgt - (tgt % 4);
    @(posedge Clk);
    if (!Reset) begin
      m_pc = 32'h0;
      m_pend.delete();
    end else if (Stall) begin
      if (PCSrc != 2'd0) begin
        m_pend.delete();
        m_pend.push_back(tgt);
      end
    end else begin
      if (PCSrc != 2'd0) m_pc = tgt;
      else if (m_pend.size() > 0) m_pc = m_pend[0];
      else m_pc = m_pc + 32'd4;
      m_pend.delete();
    end
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; Stall = 1'b0; PCSrc = 2'd3; JRTarget = 32'h1234;
    BranchTarget = 32'h0; JumpTarget = 32'h0;
    #1;
    checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", Flush); end
    tick();
    tick();
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", PC); end
    checks++; if (RedirectPending !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b want 0", RedirectPending); end
    checks++; if (PCPlus4 !== 32'h4) begin errors++; $display("FAIL reset_pcplus4: got %h want 4", PCPlus4); end
    checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL reset_flush2: got %b want 0", Flush); end
    Reset = 1'b1; PCSrc = 2'd0;
  endtask

  task automatic test_free_run();
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL run_flush[%0d]: got %b want 0", i, Flush); end
      tick();
      checks++; if (PC !== 32'(4 * i)) begin errors++; $display("FAIL run_pc[%0d]: got %h want %h", i, PC, 4 * i); end
    end
  endtask

  task automatic test_branch();
    PCSrc = 2'd1; BranchTarget = 32'h40;
    #1;
    checks++; if (Flush !== 1'b1) begin errors++; $display("FAIL branch_flush: got %b want 1", Flush); end
    tick();
    checks++; if (PC !== 32'h40) begin errors++; $display("FAIL branch_pc: got %h want 40", PC); end
    PCSrc = 2'd0;
    tick();
    checks++; if (PC !== 32'h44) begin errors++; $display("FAIL branch_pc_next: got %h want 44", PC); end
  endtask

  task automatic test_stall_redirect();
    PCSrc = 2'd3; JRTarget = 32'h20;
    tick();
    Stall = 1'b1; PCSrc = 2'd2; JumpTarget = 32'h100;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL stall_flush[%0d]: got %b want 0", i, Flush); end
      tick();
      checks++; if (PC !== 32'h20) begin errors++; $display("FAIL stall_pc[%0d]: got %h want 20", i, PC); end
      checks++; if (RedirectPending !== 1'b1) begin errors++; $display("FAIL stall_pend[%0d]: got %b want 1", i, RedirectPending); end
      PCSrc = 2'd0;
    end
    Stall = 1'b0;
    #1;
    checks++; if (Flush !== 1'b1) begin errors++; $display("FAIL release_flush: got %b want 1", Flush); end
    tick();
    checks++; if (PC !== 32'h100) begin errors++; $display("FAIL release_pc: got %h want 100", PC); end
    checks++; if (RedirectPending !== 1'b0) begin errors++; $display("FAIL release_pend: got %b want 0", RedirectPending); end
    #1;
    checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL release_flush_width: got %b want 0", Flush); end
  endtask

  task automatic test_overwrite_priority();
    Stall = 1'b1; PCSrc = 2'd2; JumpTarget = 32'h100;
    tick();
    PCSrc = 2'd3; JRTarget = 32'h203;
    tick();
    Stall = 1'b0; PCSrc = 2'd0;
    tick();
    checks++; if (PC !== 32'h200) begin errors++; $display("FAIL overwrite_pc: got %h want 200", PC); end
    Stall = 1'b1; PCSrc = 2'd2; JumpTarget = 32'h100;
    tick();
    Stall = 1'b0; PCSrc = 2'd1; BranchTarget = 32'h300;
    tick();
    checks++; if (PC !== 32'h300) begin errors++; $display("FAIL priority_pc: got %h want 300", PC); end
    checks++; if (RedirectPending !== 1'b0) begin errors++; $display("FAIL priority_pend: got %b want 0", RedirectPending); end
  endtask

  task automatic test_stall_toggle();
    Stall = 1'b1; PCSrc = 2'd1; BranchTarget = 32'h180;
    tick();
    PCSrc = 2'd0; Stall = 1'b0;
    tick();
    checks++; if (PC !== 32'h180) begin errors++; $display("FAIL toggle_load: got %h want 180", PC); end
    Stall = 1'b1;
    tick();
    Stall = 1'b0;
    #1;
    checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL toggle_flush: got %b want 0", Flush); end
    tick();
    checks++; if (PC !== 32'h184) begin errors++; $display("FAIL toggle_no_reload: got %h want 184", PC); end
  endtask

  task automatic test_wrap();
    PCSrc = 2'd3; JRTarget = 32'hFFFF_FFF8;
    tick();
    PCSrc = 2'd0;
    checks++; if (PC !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_jr: got %h want fffffff8", PC); end
    checks++; if (PCPlus4 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_p4a: got %h want fffffffc", PCPlus4); end
    tick();
    checks++; if (PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc1: got %h want fffffffc", PC); end
    checks++; if (PCPlus4 !== 32'h0) begin errors++; $display("FAIL wrap_p4b: got %h want 0", PCPlus4); end
    tick();
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL wrap_pc2: got %h want 0", PC); end
    checks++; if (PCPlus4 !== 32'h4) begin errors++; $display("FAIL wrap_p4c: got %h want 4", PCPlus4); end
  endtask

  task automatic test_async_reset();
    Stall = 1'b1; PCSrc = 2'd2; JumpTarget = 32'h500;
    tick();
    PCSrc = 2'd0;
    checks++; if (RedirectPending !== 1'b1) begin errors++; $display("FAIL areset_setup: got %b want 1", RedirectPending); end
    #2 Reset = 1'b0;
    m_pc = 32'h0;
    m_pend.delete();
    #1;
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL areset_pc: got %h want 0", PC); end
    checks++; if (RedirectPending !== 1'b0) begin errors++; $display("FAIL areset_pend: got %b want 0", RedirectPending); end
    checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL areset_flush: got %b want 0", Flush); end
    tick();
    Reset = 1'b1; Stall = 1'b0;
    tick();
    checks++; if (PC !== 32'h4) begin errors++; $display("FAIL areset_resume: got %h want 4", PC); end
  endtask

  task automatic test_random();
    logic exp_flush;
    for (int i = 0; i < 400; i++) begin
      PCSrc        = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      Stall        = ($urandom_range(0, 2) == 0);
      BranchTarget = $urandom;
      JumpTarget   = $urandom;
      JRTarget     = $urandom;
      #1;
      exp_flush = !Stall && (PCSrc != 2'd0 || m_pend.size() > 0);
      checks++; if (Flush !== exp_flush) begin errors++; $display("FAIL rnd_flush[%0d]: got %b want %b", i, Flush, exp_flush); end
      checks++; if (PCPlus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_pcplus4[%0d]: got %h want %h", i, PCPlus4, m_pc + 32'd4); end
      tick();
      checks++; if (PC !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, PC, m_pc); end
      checks++; if (RedirectPending !== (m_pend.size() > 0)) begin
        errors++; $display("FAIL rnd_pend[%0d]: got %b want %b", i, RedirectPending, m_pend.size() > 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_branch();
    test_stall_redirect();
    test_overwrite_priority();
    test_stall_toggle();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Program-counter stage of the fetch path. It consumes the 2-bit next-PC select produced by the branch/jump select stage and chooses among PC+4, branch target, jump target and jump-register target. It holds the architectural fetch PC in a register and honours pipeline stalls. A one-entry redirect buffer keeps a redirect that resolves during a stall, and a flush strobe clears the IF/ID register when a redirect takes effect.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned).
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- PCSrc  in  2  next-PC select: 0 = PC+4, 1 = BranchTarget, 2 = JumpTarget, 3 = JRTarget.
- BranchTarget  in  32  branch target from the ID-stage adder.
- JumpTarget  in  32  fully formed J/JAL target.
- JRTarget  in  32  register value for JR/JALR.
- Stall  in  1  hazard-unit stall; PC must hold while high.
- PC  out  32  registered fetch address to instruction memory.
- PCPlus4  out  32  combinational PC+4, to the IF/ID register for link values.
- Flush  out  1  combinational; IF/ID clears on the edge where a redirect loads the PC.
- RedirectPending  out  1  registered; high while a buffered redirect is waiting.

## Operation
- Internal state: PC register, pending flag, and a 32-bit pending-target register.
- Two states:
  - RUN: pending flag = 0.
  - PEND: pending flag = 1.
- Target selection: Sel = the target chosen by PCSrc (1/2/3). Bits [1:0] of every target are forced to 0 before use.
- Redirect request: Req = (PCSrc != 0).
- RUN, Stall = 0:
  - Req = 1: PC <= Sel; Flush = 1.
  - Req = 0: PC <= PC+4; Flush = 0.
- RUN, Stall = 1:
  - PC holds.
  - Req = 1: pending target <= Sel; go to PEND.
  - Flush = 0.
- PEND, Stall = 1:
  - PC holds.
  - Req = 1: pending target <= Sel (latest resolution overwrites).
  - Flush = 0.
- PEND, Stall = 0:
  - Req = 1: PC <= Sel (live request beats buffered).
  - Req = 0: PC <= pending target.
  - In both cases, Flush = 1 and the block returns to RUN.
- Arithmetic: PCPlus4 = PC + 32'd4, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Flush is never asserted while Stall = 1.
- RedirectPending = pending flag.

## Timing
- Reset asserted (Reset = 0), asynchronously: PC = RESET_PC, pending flag = 0, pending target = 0, RedirectPending = 0.
  - Flush = 0 while in reset, regardless of PCSrc.
  - PCPlus4 = RESET_PC + 4.
- Reset deasserts synchronously to the design. The first edge with Reset = 1 applies normal rules.
- Latency:
  - A redirect presented with Stall = 0 appears on PC one edge later.
  - A redirect buffered under stall appears on PC one edge after Stall falls.
- Flush is high in the same cycle as the PC-updating edge, not after it. It is one cycle wide per redirect.
- Reset mid-PEND discards the buffered target immediately.
- Stall toggling each cycle while PEND: the buffered target loads at the first Stall = 0 edge. It is never loaded twice.
- PCSrc is sampled only at rising edges. Glitches between edges have no effect on state; they may affect combinational Flush.

## Test plan
- Reset then free-run:
  - Reset = 0 for 2 cycles with RESET_PC = 0, then release with PCSrc = 0, Stall = 0.
  - Required: PC = 0, 4, 8, 12 on successive edges; Flush = 0 throughout.
- Branch redirect:
  - At PC = 0x10, PCSrc = 1, BranchTarget = 0x40.
  - Required: Flush = 1 that cycle; next PC = 0x40; then 0x44.
- Redirect under stall:
  - Stall = 1 at PC = 0x20 for 3 cycles; PCSrc = 2, JumpTarget = 0x100 in the first stall cycle; PCSrc = 0 afterwards.
  - Required: PC holds 0x20; RedirectPending = 1 from the next edge; Flush = 0 during stall.
  - When Stall drops: Flush = 1, PC = 0x100, RedirectPending = 0.
- Overwrite and priority:
  - While PEND with target 0x100, present PCSrc = 3, JRTarget = 0x203 under stall. Required: PC = 0x200 after release (low bits masked).
  - Repeat, but release Stall with PCSrc = 1, BranchTarget = 0x300. Required: PC = 0x300.
- Wrap:
  - Set PC = 0xFFFF_FFF8 via JR, run with PCSrc = 0.
  - Required: 0xFFFF_FFFC, then 0x0000_0000, with PCPlus4 matching.
- Async reset mid-operation:
  - Drop Reset between edges while PEND with target 0x500.
  - Required: PC = RESET_PC and RedirectPending = 0 immediately.
  - After release, PC continues RESET_PC+4 with no jump to 0x500.
